// File: rtl/sopc_mem_ctrl_pkg.sv
// sopc_mem_ctrl_pkg: shared FSM encodings and default widths for the SOPC memory controller blocks
package sopc_mem_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;
  localparam int DEF_NUM_PORTS   = 2;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_DEPTH_WORDS = 1024;
  localparam int DEF_WAIT_CYCLES = 1;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sopc_mem_ctrl_rr_arbiter.sv
// sopc_rr_arbiter: round-robin grant, first requester after the last granted port wins
module sopc_rr_arbiter import sopc_mem_ctrl_pkg::*; #(
  parameter int N = DEF_NUM_PORTS,
  localparam int IW = idx_w(N)
)(
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  int p;
  // scan ports starting just after the last winner, wrapping to 0
  always_comb begin
    grant = '0;
    idx = '0;
    p = 0;
    for (int i = 1; i <= N; i++) begin
      p = (int'(last) + i) % N;
      if (grant == '0 && req[p]) begin
        grant[p] = 1'b1;
        idx = IW'(p);
      end
    end
  end
endmodule

// File: rtl/sopc_mem_ctrl.sv
// sopc_mem_ctrl: multi-port round-robin SRAM controller; SOPC_MEM_RANGE_CHECK_EN adds err for out-of-range words
module sopc_mem_ctrl import sopc_mem_ctrl_pkg::*; #(
  parameter int NUM_PORTS   = DEF_NUM_PORTS,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req,
  input  logic [NUM_PORTS-1:0]              we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] sel,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata,
  output logic [NUM_PORTS-1:0]              ack,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              busy
`ifdef SOPC_MEM_RANGE_CHECK_EN
  ,
  output logic                              err
`endif
);
  localparam int BW  = DATA_WIDTH / 8;
  localparam int OFF = BW > 1 ? $clog2(BW) : 0;
  localparam int IXW = $clog2(DEPTH_WORDS);
  localparam int IW  = idx_w(NUM_PORTS);

  state_t state;
  logic [3:0] cnt;
  logic [IW-1:0] last, w_idx;
  logic [NUM_PORTS-1:0] grant, g_grant;
  logic in_idle, fire, oor;
  logic a_we, g_we;
  logic [IXW-1:0] widx, g_widx;
  logic [BW-1:0] a_sel, g_sel;
  logic [DATA_WIDTH-1:0] a_wdata, g_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  sopc_rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .req   (req),
    .last  (last),
    .grant (grant),
    .idx   (w_idx)
  );

  assign in_idle = state == S_IDLE;
  assign busy    = !in_idle;
  assign a_we    = in_idle ? we[w_idx] : g_we;
  assign a_sel   = in_idle ? sel[w_idx*BW +: BW] : g_sel;
  assign a_wdata = in_idle ? wdata[w_idx*DATA_WIDTH +: DATA_WIDTH] : g_wdata;
  assign widx    = in_idle ? addr[w_idx*ADDR_WIDTH + OFF +: IXW] : g_widx;
  assign fire    = !rst && ((state == S_WAIT && cnt == 4'd0) || (in_idle && |req && WAIT_CYCLES == 0));

`ifdef SOPC_MEM_RANGE_CHECK_EN
  logic g_oor;
  assign oor = in_idle ? |(addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH] >> (OFF + IXW)) : g_oor;
`else
  logic unused_addr;
  assign oor = 1'b0;
  assign unused_addr = &{1'b0, addr};
`endif

  // byte-masked write commits on the edge that enters ACK; storage is never cleared
  always_ff @(posedge clk)
    if (fire && a_we && !oor)
      for (int b = 0; b < BW; b++)
        if (a_sel[b]) mem[widx][b*8 +: 8] <= a_wdata[b*8 +: 8];

  // transaction FSM with registered ack/rdata and latched winner request
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      last  <= IW'(NUM_PORTS - 1);
      ack   <= '0;
      rdata <= '0;
`ifdef SOPC_MEM_RANGE_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      ack <= fire ? (in_idle ? grant : g_grant) : '0;
      if (fire && !a_we) rdata <= oor ? '0 : mem[widx];
`ifdef SOPC_MEM_RANGE_CHECK_EN
      err <= fire && oor;
`endif
      case (state)
        S_IDLE:
          if (|req) begin
            last    <= w_idx;
            g_grant <= grant;
            g_we    <= a_we;
            g_sel   <= a_sel;
            g_wdata <= a_wdata;
            g_widx  <= widx;
`ifdef SOPC_MEM_RANGE_CHECK_EN
            g_oor   <= oor;
`endif
            state   <= WAIT_CYCLES == 0 ? S_ACK : S_WAIT;
            cnt     <= WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
          end
        S_WAIT:
          if (cnt == 4'd0) state <= S_ACK;
          else cnt <= cnt - 4'd1;
        default: state <= S_IDLE;
      endcase
    end
endmodule
